// File: rtl/fir_mac_scheduler_if.sv
// Handshake/strobe bundle between the FIR MAC scheduler, the I2S2 ready
// strobes and the shared MAC datapath.
interface fir_mac_scheduler_if #(
    parameter int ADDR_W = 5
);
    logic [3:0]        switch;
    logic              left_rx_ready;
    logic              right_rx_ready;
    logic              sample_we;
    logic              ch_sel;
    logic [ADDR_W-1:0] tap_idx;
    logic [3:0]        bank;
    logic              mac_clr;
    logic              mac_en;
    logic              result_valid;
    logic              busy;
    logic              overrun;

    modport master (
        input  switch, left_rx_ready, right_rx_ready,
        output sample_we, ch_sel, tap_idx, bank, mac_clr, mac_en,
               result_valid, busy, overrun
    );

    modport slave (
        output switch, left_rx_ready, right_rx_ready,
        input  sample_we, ch_sel, tap_idx, bank, mac_clr, mac_en,
               result_valid, busy, overrun
    );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Shares one MAC datapath between left/right FIR channels; owns the coefficient bank.
// Define FIR_SCHED_ROUND_ROBIN_EN for round-robin arbitration (default: left has priority).
//
// state | meaning
// IDLE  | waiting for a pending channel; bank may be reloaded here
// LOAD  | shift new sample in, clear accumulator
// MAC   | sweep taps 0..TAPS-1 with mac_en
// DRAIN | wait PIPE_LAT cycles for the datapath pipeline to settle
// DONE  | result_valid pulse, datapath captures the sum
module fir_mac_scheduler #(
    parameter int TAPS     = 32,
    parameter int ADDR_W   = 5,
    parameter int PIPE_LAT = 2
) (
    input  logic                mclk,
    input  logic                rst_n,
    fir_mac_scheduler_if.master bus
);

    localparam int DW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, DONE} state_t;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          pend_l;
    logic          pend_r;
    logic [3:0]    sw_meta;
    logic [3:0]    sw_sync;
    logic          want_l;
    logic          want_r;
    logic          pick;

`ifdef FIR_SCHED_ROUND_ROBIN_EN
    logic          last_served;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= 1'b1;
        end else if (state == IDLE && (want_l || want_r)) begin
            last_served <= pick;
        end
    end
`endif

    // A ready pulse in the IDLE cycle starts the job on the same edge it sets pending.
    always_comb begin
        want_l = pend_l | bus.left_rx_ready;
        want_r = pend_r | bus.right_rx_ready;
`ifdef FIR_SCHED_ROUND_ROBIN_EN
        pick = (want_l && want_r) ? ~last_served : ~want_l;
`else
        pick = ~want_l;
`endif
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta     <= '0;
            sw_sync     <= '0;
            bus.bank    <= '0;
            pend_l      <= 1'b0;
            pend_r      <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            sw_meta <= bus.switch;
            sw_sync <= sw_meta;
            if (state == IDLE && !pend_l && !pend_r) begin
                bus.bank <= sw_sync;
            end
            // Set wins over the LOAD-time clear.
            pend_l <= bus.left_rx_ready  | (pend_l & ~(state == LOAD && !bus.ch_sel));
            pend_r <= bus.right_rx_ready | (pend_r & ~(state == LOAD &&  bus.ch_sel));
            bus.overrun <= bus.overrun
                         | (bus.left_rx_ready  & pend_l)
                         | (bus.right_rx_ready & pend_r);
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            drain_cnt        <= '0;
            bus.sample_we    <= 1'b0;
            bus.ch_sel       <= 1'b0;
            bus.tap_idx      <= '0;
            bus.mac_clr      <= 1'b0;
            bus.mac_en       <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.sample_we    <= 1'b0;
            bus.mac_clr      <= 1'b0;
            bus.mac_en       <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.tap_idx      <= '0;
            case (state)
                IDLE: begin
                    if (want_l || want_r) begin
                        state         <= LOAD;
                        bus.ch_sel    <= pick;
                        bus.sample_we <= 1'b1;
                        bus.mac_clr   <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    state       <= MAC;
                    bus.mac_en  <= 1'b1;
                end
                MAC: begin
                    if (bus.tap_idx == ADDR_W'(TAPS - 1)) begin
                        if (PIPE_LAT == 0) begin
                            state            <= DONE;
                            bus.result_valid <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(PIPE_LAT - 1);
                        end
                    end else begin
                        bus.mac_en  <= 1'b1;
                        bus.tap_idx <= bus.tap_idx + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state            <= DONE;
                        bus.result_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus.ch_sel <= 1'b0;
                    bus.busy   <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: vector table plus a result scoreboard
// keyed on channel and the cycle each RESULT_VALID is due.
module tb_fir_mac_scheduler;

    localparam int TAPS     = 32;
    localparam int ADDR_W   = 5;
    localparam int PIPE_LAT = 2;
    localparam int LAT      = TAPS + PIPE_LAT + 2;
    localparam int NEXT     = LAT + 1;

    typedef struct {
        bit         l;
        bit         r;
        logic [3:0] sw;
        int         exp_n;
    } vec_t;

    typedef struct {
        bit ch;
        int due;
    } exp_t;

    logic mclk;
    logic rst_n;
    int   cyc;
    int   total;
    int   passed;
    int   rv_count;
    int   ntaps;
    exp_t q[$];
    vec_t vecs[5];

    fir_mac_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    fir_mac_scheduler #(
        .TAPS(TAPS),
        .ADDR_W(ADDR_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .mclk (mclk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    task automatic step();
        @(negedge mclk);
    endtask

    task automatic pulse(input bit l, input bit r, output int p);
        p = cyc;
        bus.left_rx_ready  = l;
        bus.right_rx_ready = r;
        step();
        bus.left_rx_ready  = 1'b0;
        bus.right_rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((bus.busy || q.size() != 0) && n < max) begin
            step();
            n++;
        end
        chk("idle_within_budget", (n < max), 1);
    endtask

    always @(negedge mclk) begin
        if (rst_n) begin
            if (bus.mac_clr) ntaps = 0;
            if (bus.mac_en) begin
                if (bus.tap_idx !== ADDR_W'(ntaps)) begin
                    total++;
                    $display("FAIL tap_idx: got %0d expected %0d (cycle %0d)", bus.tap_idx, ntaps, cyc);
                end
                ntaps++;
            end
            if (bus.result_valid) begin
                rv_count++;
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_result: got ch %0d expected none (cycle %0d)", bus.ch_sel, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result_ch", bus.ch_sel, e.ch);
                    chk("result_cycle", cyc, e.due);
                    chk("taps_swept", ntaps, TAPS);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, p2, rv0;
        total = 0; passed = 0; rv_count = 0; ntaps = 0;
        vecs[0] = '{l: 1'b1, r: 1'b0, sw: 4'd3, exp_n: 1};
        vecs[1] = '{l: 1'b0, r: 1'b1, sw: 4'd7, exp_n: 1};
        vecs[2] = '{l: 1'b1, r: 1'b1, sw: 4'd5, exp_n: 2};
        vecs[3] = '{l: 1'b1, r: 1'b1, sw: 4'd9, exp_n: 2};
        vecs[4] = '{l: 1'b0, r: 1'b1, sw: 4'd0, exp_n: 1};

        rst_n = 1'b0;
        bus.switch = 4'd0;
        bus.left_rx_ready = 1'b0;
        bus.right_rx_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_bank", bus.bank, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_tap_idx", bus.tap_idx, 0);
        chk("rst_mac_en", bus.mac_en, 0);
        chk("rst_result_valid", bus.result_valid, 0);

        // Single left pulse at cycle 10: LOAD 11, MAC 12..43, RESULT_VALID 46, idle 47.
        while (cyc < 10) step();
        q.push_back('{ch: 1'b0, due: 10 + LAT});
        pulse(1'b1, 1'b0, p);
        chk("load_busy", bus.busy, 1);
        chk("load_sample_we", bus.sample_we, 1);
        chk("load_mac_clr", bus.mac_clr, 1);
        chk("load_ch_sel", bus.ch_sel, 0);
        chk("load_mac_en", bus.mac_en, 0);
        step();
        chk("mac_first_en", bus.mac_en, 1);
        chk("mac_first_tap", bus.tap_idx, 0);
        while (cyc < 43) step();
        chk("mac_last_en", bus.mac_en, 1);
        chk("mac_last_tap", bus.tap_idx, TAPS - 1);
        step();
        chk("drain_mac_en", bus.mac_en, 0);
        chk("drain_tap_idx", bus.tap_idx, 0);
        chk("drain_busy", bus.busy, 1);
        while (cyc < 46) step();
        chk("done_valid", bus.result_valid, 1);
        step();
        chk("idle_busy", bus.busy, 0);
        chk("idle_valid", bus.result_valid, 0);

        for (int i = 0; i < 5; i++) begin
            bus.switch = vecs[i].sw;
            repeat (5) step();
            rv0 = rv_count;
            if (vecs[i].l && vecs[i].r) begin
                q.push_back('{ch: 1'b0, due: cyc + LAT});
                q.push_back('{ch: 1'b1, due: cyc + LAT + NEXT});
            end else begin
                q.push_back('{ch: vecs[i].r, due: cyc + LAT});
            end
            pulse(vecs[i].l, vecs[i].r, p);
            wait_idle(200);
            chk("vec_results", rv_count - rv0, vecs[i].exp_n);
            chk("vec_bank", bus.bank, vecs[i].sw);
            chk("vec_overrun", bus.overrun, 0);
        end

        // Second left pulse while left is still pending -> sticky overrun, one left result.
        bus.switch = 4'd0;
        repeat (5) step();
        rv0 = rv_count;
        q.push_back('{ch: 1'b1, due: cyc + LAT});
        q.push_back('{ch: 1'b0, due: cyc + LAT + NEXT});
        pulse(1'b0, 1'b1, p);
        repeat (4) step();
        pulse(1'b1, 1'b0, p2);
        chk("ovr_before", bus.overrun, 0);
        repeat (4) step();
        pulse(1'b1, 1'b0, p2);
        chk("ovr_set", bus.overrun, 1);
        wait_idle(200);
        chk("ovr_results", rv_count - rv0, 2);
        chk("ovr_held", bus.overrun, 1);

        // Right job, then both pending during it: left goes first afterwards.
        repeat (3) step();
        rv0 = rv_count;
        q.push_back('{ch: 1'b1, due: cyc + LAT});
        q.push_back('{ch: 1'b0, due: cyc + LAT + NEXT});
        q.push_back('{ch: 1'b1, due: cyc + LAT + 2 * NEXT});
        pulse(1'b0, 1'b1, p);
        repeat (5) step();
        pulse(1'b1, 1'b1, p2);
        wait_idle(300);
        chk("arb_results", rv_count - rv0, 3);

        // SWITCH change mid-job waits for the job to finish.
        repeat (3) step();
        chk("bank_start", bus.bank, 0);
        q.push_back('{ch: 1'b0, due: cyc + LAT});
        pulse(1'b1, 1'b0, p);
        repeat (2) step();
        bus.switch = 4'd5;
        repeat (20) step();
        chk("bank_mid_job", bus.bank, 0);
        wait_idle(100);
        chk("bank_first_idle", bus.bank, 0);
        step();
        chk("bank_loaded", bus.bank, 5);

        // One-cycle SWITCH glitch during a job leaves BANK alone.
        q.push_back('{ch: 1'b1, due: cyc + LAT});
        pulse(1'b0, 1'b1, p);
        repeat (5) step();
        bus.switch = 4'd9;
        step();
        bus.switch = 4'd5;
        wait_idle(100);
        repeat (5) step();
        chk("bank_glitch", bus.bank, 5);

        // Reset in the middle of the tap sweep aborts the job.
        q.push_back('{ch: 1'b0, due: cyc + LAT});
        pulse(1'b1, 1'b0, p);
        while (cyc < p + 12) step();
        chk("pre_rst_tap", bus.tap_idx, 10);
        rst_n = 1'b0;
        #1;
        chk("abort_mac_en", bus.mac_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_tap_idx", bus.tap_idx, 0);
        chk("abort_bank", bus.bank, 0);
        q.delete();
        step(); step();
        rst_n = 1'b1;
        chk("abort_overrun", bus.overrun, 0);
        rv0 = rv_count;
        repeat (60) step();
        chk("abort_no_result", rv_count - rv0, 0);
        chk("abort_idle", bus.busy, 0);
        q.push_back('{ch: 1'b1, due: cyc + LAT});
        pulse(1'b0, 1'b1, p);
        wait_idle(100);
        chk("post_rst_results", rv_count - rv0, 1);
        chk("scoreboard_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

- Time-multiplexes one shared multiply-accumulate datapath between the left and right audio channels of the pipelined FIR.
- Sits between the I2S2 transceiver ready strobes and the FIR datapath. It sequences sample write, accumulator clear, the tap sweep and result capture.
- Owns the active coefficient bank and switches it only between sample jobs, so a bank change never corrupts a sum in flight.

## Interface

Parameters:
- TAPS, 32, number of filter taps swept per job (≥2)
- ADDR_W, 5, width of TAP_IDX; must satisfy 2^ADDR_W ≥ TAPS
- PIPE_LAT, 2, datapath latency in cycles from the last MAC_EN to a stable accumulator (≥0)

Ports:
- MCLK  in  1  sole clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- SWITCH  in  4  requested coefficient bank; asynchronous to MCLK
- LEFT_RX_READY  in  1  one-cycle pulse: new left sample available
- RIGHT_RX_READY  in  1  one-cycle pulse: new right sample available
- SAMPLE_WE  out  1  shift the CH_SEL channel's new sample into its delay line
- CH_SEL  out  1  channel in service: 0 = left, 1 = right
- TAP_IDX  out  ADDR_W  tap / coefficient address for the current MAC cycle
- BANK  out  4  active coefficient bank
- MAC_CLR  out  1  zero the accumulator
- MAC_EN  out  1  accumulate product at TAP_IDX
- RESULT_VALID  out  1  one-cycle pulse: datapath latches the accumulator into LEFT_TX or RIGHT_TX, selected by CH_SEL
- BUSY  out  1  high in any state other than IDLE
- OVERRUN  out  1  sticky: a sample arrived while that channel was already pending

## Operation

Pending flags:
- PEND_L and PEND_R are set by their ready pulses and cleared when that channel's job enters LOAD.
- A set and a clear in the same cycle resolve to set (1).

Bank select:
- SWITCH passes through a 2-flop synchronizer.
- BANK loads the synchronized value only in IDLE with PEND_L=PEND_R=0.
- BANK is therefore constant for the whole of each job.

FSM states and transitions:
- IDLE → LOAD when any pending flag is set; the channel is chosen by arbitration.
- LOAD: one cycle with SAMPLE_WE=1 and MAC_CLR=1; the chosen channel's pending flag is cleared. → MAC.
- MAC: TAPS cycles with MAC_EN=1; TAP_IDX steps 0..TAPS-1. → DRAIN after TAP_IDX=TAPS-1.
- DRAIN: PIPE_LAT cycles with all strobes low. If PIPE_LAT=0, DRAIN is skipped. → DONE.
- DONE: one cycle with RESULT_VALID=1. → IDLE.

Arbitration:
- With one channel pending, that channel is served.
- With both pending, see Configuration.
- CH_SEL is registered at the IDLE→LOAD transition and held until IDLE is re-entered.

OVERRUN:
- Set when a ready pulse arrives for a channel whose pending flag is already 1.
- That sample is not separately processed; the datapath's RX register holds the newer value.
- Cleared only by reset.

Outputs outside their listed state are 0; TAP_IDX holds 0 outside MAC.

## Timing

- Reset values: all outputs 0, BANK=0, pending flags 0, FSM in IDLE, last-served = right.
- A ready pulse at edge n sets pending at edge n+1. The FSM is in LOAD during cycle n+1 if it was idle.
- Job length is 1 + TAPS + PIPE_LAT + 1 cycles. Default: 36 cycles from LOAD to the end of DONE.
- Pulse-to-RESULT_VALID latency when idle: TAPS + PIPE_LAT + 2 cycles.
- Back-to-back jobs: DONE → IDLE (1 cycle) → LOAD. A channel pending at DONE starts 2 cycles after DONE.
- Reset asserted mid-job: immediate abort. No RESULT_VALID is issued and all outputs go to 0 asynchronously.
- SWITCH change: reaches BANK no sooner than 3 edges later, and only at a qualifying IDLE cycle.

## Configuration

FIR_SCHED_ROUND_ROBIN_EN:
- Defined: when both channels are pending, serve the channel not served last. Last-served resets to right, so left goes first after reset.
- Undefined: fixed priority, left always wins over right.

## Test plan

- Reset then single LEFT_RX_READY pulse at cycle 10 -> LOAD at cycle 11; MAC_EN high for cycles 12–43 with TAP_IDX 0..31; RESULT_VALID at cycle 46 with CH_SEL=0; BUSY low at cycle 47.
- LEFT and RIGHT pulses in the same cycle -> left job, then right job with LOAD 2 cycles after left DONE; OVERRUN stays 0.
- Round-robin build: right pulse, then both pulses during the right job -> after right DONE, left is served first. Fixed-priority build with both pending -> left served first.
- Second LEFT pulse while PEND_L=1 (right job active) -> OVERRUN=1 and held; exactly one left RESULT_VALID follows.
- SWITCH 0→5 mid-job -> BANK stays 0 until the job ends and both flags are clear, then becomes 5. SWITCH toggled for only 1 cycle while a job is active -> BANK unchanged.
- RST_N low during MAC (TAP_IDX=10) -> MAC_EN, BUSY and TAP_IDX at 0 immediately. After release, no RESULT_VALID until a new ready pulse arrives.
